// File: rtl/cmt_pkg.sv
// rtl/cmt_pkg.sv - shared types and constants for the CMT job sequencer
package cmt_pkg;

  localparam int WORDS_PER_CL = 8;
  localparam int CNT_W        = 17;

  typedef logic [CNT_W-1:0] cmt_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIZE,
    ST_KERNEL,
    ST_DATA,
    ST_DRAIN,
    ST_PAD,
    ST_DONE
  } cmt_seq_state_t;

endpackage

// File: rtl/cmt_size_calc.sv
// rtl/cmt_size_calc.sv - registered per-job transfer sizes derived from element size N
module cmt_size_calc
  import cmt_pkg::*;
#(
  parameter int NW         = 6,
  parameter int MAX_N      = 32,
  parameter int CL_WORDS   = 8,
  parameter int SIZE_WIDTH = 16,
  parameter int PAD_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [NW-1:0]         n_i,
  output logic                  legal_o,
  output cmt_cnt_t              n2_o,
  output cmt_cnt_t              n3_o,
  output cmt_cnt_t              res_tot_o,
  output logic [SIZE_WIDTH-1:0] rd_cl_o,
  output logic [SIZE_WIDTH-1:0] wr_cl_o,
  output logic [PAD_W-1:0]      pad_o
);

  cmt_cnt_t n_ext, n2, n3, tot, rem, pad_full;
  cmt_cnt_t n2_q, n3_q, tot_q;
  logic [SIZE_WIDTH-1:0] rd_q, wr_q;
  logic [PAD_W-1:0]      pad_q;

  // Products are only meaningful for legal N; illegal N zeroes every size.
  always_comb begin
    n_ext    = cmt_cnt_t'(n_i);
    n2       = n_ext * n_ext;
    n3       = n2 * n_ext;
    tot      = (n3 << 1) + n3;
    rem      = tot % cmt_cnt_t'(CL_WORDS);
    pad_full = (cmt_cnt_t'(CL_WORDS) - rem) % cmt_cnt_t'(CL_WORDS);
  end

  assign legal_o = (n_i != '0) && (n_ext <= cmt_cnt_t'(MAX_N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n2_q  <= '0;
      n3_q  <= '0;
      tot_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      pad_q <= '0;
    end else if (en_i) begin
      if (legal_o) begin
        n2_q  <= n2;
        n3_q  <= n3;
        tot_q <= tot;
        rd_q  <= SIZE_WIDTH'((n2 + n3 + cmt_cnt_t'(CL_WORDS - 1)) / cmt_cnt_t'(CL_WORDS));
        wr_q  <= SIZE_WIDTH'((tot + cmt_cnt_t'(CL_WORDS - 1)) / cmt_cnt_t'(CL_WORDS));
        pad_q <= PAD_W'(pad_full);
      end else begin
        n2_q  <= '0;
        n3_q  <= '0;
        tot_q <= '0;
        rd_q  <= '0;
        wr_q  <= '0;
        pad_q <= '0;
      end
    end
  end

  assign n2_o      = n2_q;
  assign n3_o      = n3_q;
  assign res_tot_o = tot_q;
  assign rd_cl_o   = rd_q;
  assign wr_cl_o   = wr_q;
  assign pad_o     = pad_q;

endmodule

// File: rtl/cmt_job_sequencer.sv
// rtl/cmt_job_sequencer.sv - per-job steering of input words to the pipeline and results to the output buffer
module cmt_job_sequencer #(
  parameter int WIDTH        = 64,
  parameter int MAX_N        = 32,
  parameter int WORDS_PER_CL = 8,
  parameter int SIZE_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [$clog2(MAX_N+1)-1:0] n_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [SIZE_WIDTH-1:0]      rd_cl,
  output logic [SIZE_WIDTH-1:0]      wr_cl,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       stall,
  output logic [WIDTH-1:0]           kernel_out,
  output logic                       kernel_vld,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_vld,
  input  logic [WIDTH-1:0]           res_data,
  input  logic                       res_vld,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_vld
);
  import cmt_pkg::*;

  localparam int NW    = $clog2(MAX_N + 1);
  localparam int PAD_W = $clog2(WORDS_PER_CL + 1);

  cmt_seq_state_t   state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  cmt_cnt_t         in_cnt_q, in_cnt_d;
  cmt_cnt_t         res_cnt_q, res_cnt_d;
  logic [PAD_W-1:0] pad_q, pad_d;
  logic             err_q, err_d;

  logic             n_legal;
  cmt_cnt_t         n2, n3, res_tot;
  logic [PAD_W-1:0] pad_len;
  logic             res_win;

  cmt_size_calc #(
    .NW        (NW),
    .MAX_N     (MAX_N),
    .CL_WORDS  (WORDS_PER_CL),
    .SIZE_WIDTH(SIZE_WIDTH),
    .PAD_W     (PAD_W)
  ) u_size (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == ST_SIZE),
    .n_i      (n_q),
    .legal_o  (n_legal),
    .n2_o     (n2),
    .n3_o     (n3),
    .res_tot_o(res_tot),
    .rd_cl_o  (rd_cl),
    .wr_cl_o  (wr_cl),
    .pad_o    (pad_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      in_cnt_q  <= '0;
      res_cnt_q <= '0;
      pad_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      in_cnt_q  <= in_cnt_d;
      res_cnt_q <= res_cnt_d;
      pad_q     <= pad_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    in_cnt_d   = in_cnt_q;
    res_cnt_d  = res_cnt_q;
    pad_d      = pad_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    kernel_vld = 1'b0;
    data_vld   = 1'b0;
    out_vld    = 1'b0;
    out_data   = res_data;

    // Results may arrive while inputs are still streaming; surplus ones are dropped.
    res_win = (state_q == ST_KERNEL) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
    if (res_win && res_vld && !stall) begin
      if (res_cnt_q == res_tot) begin
        err_d = 1'b1;
      end else begin
        res_cnt_d = res_cnt_q + 1'b1;
        out_vld   = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d   = ST_SIZE;
          n_d       = n_in;
          in_cnt_d  = '0;
          res_cnt_d = '0;
          pad_d     = '0;
          err_d     = 1'b0;
        end
      end
      ST_SIZE: begin
        if (!n_legal) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_KERNEL;
        end
      end
      ST_KERNEL, ST_DATA: begin
        in_ready   = in_valid && !stall;
        kernel_vld = in_ready && (state_q == ST_KERNEL);
        data_vld   = in_ready && (state_q == ST_DATA);
        if (in_ready) in_cnt_d = in_cnt_q + 1'b1;
        // One cumulative input count: kernel words first, data words after.
        if (kernel_vld && (in_cnt_d == n2)) state_d = ST_DATA;
        if (data_vld && (in_cnt_d == n2 + n3)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_cnt_d == res_tot) begin
          if (pad_len != '0) begin
            state_d = ST_PAD;
            pad_d   = pad_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAD: begin
        out_data = '0;
        out_vld  = !stall;
        if (!stall) begin
          pad_d = pad_q - 1'b1;
          if (pad_q == PAD_W'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign kernel_out = in_data;
  assign data_out   = in_data;

endmodule

// File: tb/tb_cmt_job_sequencer.sv
// tb/tb_cmt_job_sequencer.sv - randomized self-checking bench for cmt_job_sequencer
module tb_cmt_job_sequencer;

  localparam int WIDTH = 64;
  localparam int MAX_N = 32;
  localparam int SW    = 16;
  localparam int NW    = $clog2(MAX_N + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             go = 1'b0;
  logic [NW-1:0]    n_in = '0;
  logic             busy, done, err;
  logic [SW-1:0]    rd_cl, wr_cl;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             stall = 1'b0;
  logic [WIDTH-1:0] kernel_out, data_out, out_data;
  logic             kernel_vld, data_vld, out_vld;
  logic [WIDTH-1:0] res_data = '0;
  logic             res_vld = 1'b0;

  cmt_job_sequencer #(
    .WIDTH(WIDTH), .MAX_N(MAX_N), .WORDS_PER_CL(8), .SIZE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .n_in(n_in),
    .busy(busy), .done(done), .err(err), .rd_cl(rd_cl), .wr_cl(wr_cl),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .kernel_out(kernel_out), .kernel_vld(kernel_vld),
    .data_out(data_out), .data_vld(data_vld),
    .res_data(res_data), .res_vld(res_vld),
    .out_data(out_data), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Observed traffic, tallied between edges.
  int k_cnt, d_cnt, r_cnt, p_cnt, drop_cnt, res_given, in_acc, bad;
  int exp_k, exp_in, exp_r, cyc;

  task automatic clear_tally();
    k_cnt = 0; d_cnt = 0; r_cnt = 0; p_cnt = 0; drop_cnt = 0;
    res_given = 0; in_acc = 0; bad = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (in_ready) in_acc++;
      if (kernel_vld) begin
        k_cnt++;
        if (kernel_out !== in_data || !in_ready || data_vld || d_cnt != 0) bad++;
      end
      if (data_vld) begin
        d_cnt++;
        if (data_out !== in_data || !in_ready || k_cnt != exp_k) bad++;
      end
      if (in_ready && !kernel_vld && !data_vld) bad++;
      if (stall && (in_ready || out_vld)) bad++;
      if (res_vld && !stall) begin
        res_given++;
        if (out_vld) begin
          r_cnt++;
          if (out_data !== res_data) bad++;
        end else begin
          drop_cnt++;
        end
      end else if (out_vld) begin
        p_cnt++;
        if (out_data !== '0) bad++;
      end
    end
  end

  task automatic step(input int mode);
    @(posedge clk); #1;
    cyc++;
    case (mode)
      0:       stall = 1'b0;
      1:       stall = ((cyc / 3) % 2) == 1;
      default: stall = ($urandom_range(3) == 0);
    endcase
    in_valid = (in_acc < exp_in) && ($urandom_range(3) != 0);
    in_data  = {$urandom, $urandom};
    res_vld  = (in_acc > 0) && (res_given < exp_r) && ($urandom_range(4) < 3);
    res_data = {$urandom, $urandom};
  endtask

  task automatic run_job(input int n, input int mode, input bit abort);
    bit legal;
    int exp_rd, exp_wr, exp_pad, c;
    bit quit;
    legal   = (n >= 1) && (n <= MAX_N);
    exp_k   = legal ? n * n : 0;
    exp_in  = legal ? n * n + n * n * n : 0;
    exp_r   = legal ? 3 * n * n * n : 0;
    exp_rd  = (exp_in + 7) / 8;
    exp_wr  = (exp_r + 7) / 8;
    exp_pad = (8 - exp_r % 8) % 8;
    clear_tally();
    @(posedge clk); #1;
    go = 1'b1; n_in = NW'(n); stall = 1'b0; in_valid = 1'b0; res_vld = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    check_eq($sformatf("busy_after_go_n%0d", n), busy, 1);
    c = 0; quit = 0;
    while (!done && c < 20000 && !quit) begin
      step(mode);
      c++;
      if (abort && d_cnt >= 20) quit = 1;
    end
    if (abort) begin
      #3;
      in_valid = 1'b1; res_vld = 1'b1; stall = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_done", done, 0);
      check_eq("rst_mid_err", err, 0);
      check_eq("rst_mid_rd_cl", rd_cl, 0);
      check_eq("rst_mid_wr_cl", wr_cl, 0);
      check_eq("rst_mid_hs", {in_ready, kernel_vld, data_vld, out_vld}, 0);
      in_valid = 1'b0; res_vld = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      return;
    end
    if (!done) check_eq($sformatf("timeout_n%0d", n), 1, 0);
    stall = 1'b0; in_valid = 1'b0; res_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq($sformatf("done_n%0d", n), done, 1);
    check_eq($sformatf("busy_end_n%0d", n), busy, 0);
    check_eq($sformatf("err_n%0d", n), err, legal ? 0 : 1);
    check_eq($sformatf("rd_cl_n%0d", n), rd_cl, exp_rd);
    check_eq($sformatf("wr_cl_n%0d", n), wr_cl, exp_wr);
    check_eq($sformatf("kernel_words_n%0d", n), k_cnt, exp_k);
    check_eq($sformatf("data_words_n%0d", n), d_cnt, exp_in - exp_k);
    check_eq($sformatf("result_writes_n%0d", n), r_cnt, exp_r);
    check_eq($sformatf("pad_writes_n%0d", n), p_cnt, exp_pad);
    check_eq($sformatf("dropped_n%0d", n), drop_cnt, 0);
    check_eq($sformatf("protocol_n%0d", n), bad, 0);
  endtask

  task automatic run_illegal(input int n);
    clear_tally();
    exp_k = 0;
    @(posedge clk); #1;
    go = 1'b1; n_in = NW'(n); in_valid = 1'b1; res_vld = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    check_eq($sformatf("illegal_done_n%0d", n), done, 1);
    check_eq($sformatf("illegal_err_n%0d", n), err, 1);
    check_eq($sformatf("illegal_rd_cl_n%0d", n), rd_cl, 0);
    check_eq($sformatf("illegal_wr_cl_n%0d", n), wr_cl, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq($sformatf("illegal_handshakes_n%0d", n), in_acc + r_cnt + p_cnt, 0);
    in_valid = 1'b0; res_vld = 1'b0;
  endtask

  task automatic run_surplus();
    int c;
    clear_tally();
    exp_k = 4;
    @(posedge clk); #1;
    go = 1'b1; n_in = NW'(2); in_valid = 1'b0; res_vld = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
      res_vld = 1'b1; res_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    res_vld = 1'b0;
    c = 0;
    while (in_acc < 12 && c < 200) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    c = 0;
    while (!done && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("surplus_done", done, 1);
    check_eq("surplus_err", err, 1);
    check_eq("surplus_written", r_cnt, 24);
    check_eq("surplus_dropped", drop_cnt, 1);
    check_eq("surplus_pad", p_cnt, 0);
    check_eq("surplus_inputs", {k_cnt[15:0], d_cnt[15:0]}, {16'd4, 16'd8});
    check_eq("surplus_protocol", bad, 0);
  endtask

  initial begin
    cyc = 0;
    exp_k = 0; exp_in = 0; exp_r = 0;
    clear_tally();
    #12;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_sizes", {rd_cl, wr_cl}, 0);
    check_eq("reset_valids", {in_ready, kernel_vld, data_vld, out_vld}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_job(8, 0, 1'b0);
    run_job(3, 0, 1'b0);
    run_job(8, 1, 1'b0);
    run_illegal(0);
    run_illegal(33);
    run_surplus();
    run_job(8, 2, 1'b1);
    run_job(2, 2, 1'b0);
    run_job(1, 2, 1'b0);
    for (int j = 0; j < 4; j++) run_job($urandom_range(6, 1), 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
